// File: rtl/mux2_stream_arbiter_if.sv
// mux2_stream_arbiter_if: two valid/ready source streams merged into one registered output stream
// Ports (by group):
//   a_valid/a_data/a_ready  source A handshake and payload
//   b_valid/b_data/b_ready  source B handshake and payload
//   sel                     mux select, 0=A 1=B
//   out_valid/out_data/out_src/out_ready  merged output stream
// slave is the arbiter side, master is the side driving sources and sinking output.
interface mux2_stream_arbiter_if #(parameter int DATA_W = 8);
  logic a_valid, a_ready, b_valid, b_ready, sel, out_valid, out_src, out_ready;
  logic [DATA_W-1:0] a_data, b_data, out_data;
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, sel, out_valid, out_data, out_src
  );
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: round-robin 2:1 stream arbiter with bounded bursts and a 1-entry output register
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave modport: A/B sources in, mux select and registered output stream out
module mux2_stream_arbiter #(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  mux2_stream_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] dat, dat_n;
  logic last, last_n, vld, vld_n, src, src_n;
  logic ld, gnt, g_b, same;
  always_comb begin
    ld = ~vld | bus.out_ready;
    gnt = bus.a_valid | bus.b_valid;
    // Contested: IDLE alternates from last; a serving owner keeps the grant until its burst saturates.
    g_b = (bus.a_valid & bus.b_valid)
        ? (state == IDLE ? ~last : ((state == SERVE_B) ^ (cnt == CNT_MAX)))
        : bus.b_valid;
    same = g_b ? (state == SERVE_B) : (state == SERVE_A);
    state_n = state;
    cnt_n = cnt;
    last_n = last;
    vld_n = vld;
    dat_n = dat;
    src_n = src;
    if (ld) begin
      vld_n = gnt;
      state_n = !gnt ? IDLE : (g_b ? SERVE_B : SERVE_A);
      cnt_n = !gnt ? '0 : (same ? (cnt == CNT_MAX ? cnt : cnt + 1'b1) : CNT_W'(1));
      dat_n = gnt ? (g_b ? bus.b_data : bus.a_data) : dat;
      src_n = gnt ? g_b : src;
      last_n = gnt ? g_b : last;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      vld <= 1'b0;
      dat <= '0;
      src <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last <= last_n;
      vld <= vld_n;
      dat <= dat_n;
      src <= src_n;
    end
  end
  // Readies are gated by rst_n so nothing is accepted while reset is held.
  assign bus.a_ready = rst_n & ld & gnt & ~g_b;
  assign bus.b_ready = rst_n & ld & gnt & g_b;
  assign bus.sel = gnt ? g_b : last;
  assign bus.out_valid = vld;
  assign bus.out_data = dat;
  assign bus.out_src = src;
endmodule
